// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer queue: FSM state encoding,
// default sizing, and the byte/config word widths.
package spi_pkg;

    localparam int DEPTH_DEFAULT   = 8;
    localparam int TIMEOUT_DEFAULT = 1024;
    localparam int BYTE_W          = 8;
    localparam int CFG_W           = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output; pushes
// while full and pops while empty are dropped.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o    = wr_q - rd_q;
    assign pop_data_o = mem_q[rd_q[AW-1:0]];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign wr_d       = push_ok ? wr_q + 1'b1 : wr_q;
    assign rd_d       = pop_ok ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/spi_xfer_queue.sv
// Queues host bytes for a byte-wide SPI core, launches one transfer at a time,
// and collects replies on rising edges of the core's completion signal.
module spi_xfer_queue
    import spi_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BYTE_W-1:0]      tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [BYTE_W-1:0]      rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    input  logic [CFG_W-1:0]       cfg_in,
    input  logic                   cfg_we,
    input  logic                   clr_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   err_timeout,
    output logic                   err_cfg,
    output logic [CFG_W-1:0]       data_config,
    output logic                   trans_en,
    output logic [BYTE_W-1:0]      i_data_p,
    input  logic [BYTE_W-1:0]      o_data_p,
    input  logic                   interupt_request
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              err_to_q, err_to_d;
    logic              err_cfg_q, err_cfg_d;
    logic              irq_prev_q;
    logic              irq_rise;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [BYTE_W-1:0] tx_head;
    logic              tx_pop, rx_push, set_to, set_cfg;

    spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push_i(tx_valid && tx_ready), .push_data_i(tx_data),
        .pop_i(tx_pop), .pop_data_o(tx_head),
        .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
    );

    spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push_i(rx_push), .push_data_i(o_data_p),
        .pop_i(rx_ready && rx_valid), .pop_data_o(rx_data),
        .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
    );

    assign tx_ready    = !tx_full;
    assign rx_valid    = !rx_empty;
    assign busy        = (state_q != ST_IDLE);
    assign trans_en    = (state_q == ST_START);
    assign i_data_p    = data_q;
    assign data_config = cfg_q;
    assign err_timeout = err_to_q;
    assign err_cfg     = err_cfg_q;
    // The edge register tracks the core line in every state, so a level that is
    // already high when WAIT begins can never look like a fresh completion.
    assign irq_rise    = interupt_request && !irq_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        set_to  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Only launch when the reply is guaranteed a slot in the RX queue.
                if (!tx_empty && !rx_full) begin
                    tx_pop  = 1'b1;
                    data_d  = tx_head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (irq_rise) begin
                    rx_push = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    set_to  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_d   = cfg_q;
        set_cfg = 1'b0;
        if (cfg_we) begin
            if (state_q == ST_IDLE) begin
                cfg_d = cfg_in;
            end else begin
                set_cfg = 1'b1;
            end
        end
        err_to_d  = set_to || (err_to_q && !clr_err);
        err_cfg_d = set_cfg || (err_cfg_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            cfg_q      <= '0;
            err_to_q   <= 1'b0;
            err_cfg_q  <= 1'b0;
            irq_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            err_to_q   <= err_to_d;
            err_cfg_q  <= err_cfg_d;
            irq_prev_q <= interupt_request;
        end
    end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue: a queue-based transfer model checked every
// cycle, an emulated SPI core, and hand-computed checkpoints per scenario.
module tb_spi_xfer_queue;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [31:0] cfg_in = 32'h0;
    logic        cfg_we = 1'b0;
    logic        clr_err = 1'b0;
    logic        busy;
    logic [3:0]  tx_level, rx_level;
    logic        err_timeout, err_cfg;
    logic [31:0] data_config;
    logic        trans_en;
    logic [7:0]  i_data_p;
    logic [7:0]  o_data_p = 8'h00;
    logic        interupt_request = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    spi_xfer_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cfg_in(cfg_in), .cfg_we(cfg_we), .clr_err(clr_err),
        .busy(busy), .tx_level(tx_level), .rx_level(rx_level),
        .err_timeout(err_timeout), .err_cfg(err_cfg),
        .data_config(data_config), .trans_en(trans_en),
        .i_data_p(i_data_p), .o_data_p(o_data_p),
        .interupt_request(interupt_request)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age: -1 no transfer in flight, 0 launch cycle, k>=1 k-th cycle awaiting reply.
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    int          m_age = -1;
    logic [7:0]  m_cur = 8'h00;
    logic [31:0] m_cfg = 32'h0;
    logic        m_eto = 1'b0, m_ecfg = 1'b0, m_prev = 1'b0;
    int          m_ntx, m_nrx, m_xfers = 0;
    logic        m_set_to, m_set_cfg;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_txq.delete(); m_rxq.delete();
            m_age = -1; m_cur = 8'h00; m_cfg = 32'h0;
            m_eto = 1'b0; m_ecfg = 1'b0; m_prev = 1'b0;
        end else begin
            m_ntx = m_txq.size();
            m_nrx = m_rxq.size();
            m_set_to = 1'b0;
            m_set_cfg = 1'b0;
            if (cfg_we) begin
                if (m_age < 0) m_cfg = cfg_in;
                else m_set_cfg = 1'b1;
            end
            if (m_age < 0) begin
                if (m_ntx > 0 && m_nrx < DEPTH) begin
                    m_cur = m_txq.pop_front();
                    m_age = 0;
                end
            end else if (interupt_request && !m_prev && m_age >= 1) begin
                m_rxq.push_back(o_data_p);
                m_xfers++;
                $display("xfer %0d: sent %02h received %02h", m_xfers, m_cur, o_data_p);
                m_age = -1;
            end else if (m_age == TO) begin
                m_set_to = 1'b1;
                m_xfers++;
                $display("xfer %0d: sent %02h no reply, timed out", m_xfers, m_cur);
                m_age = -1;
            end else begin
                m_age++;
            end
            if (rx_ready && m_nrx > 0) void'(m_rxq.pop_front());
            if (tx_valid && m_ntx < DEPTH) m_txq.push_back(tx_data);
            m_eto  = m_set_to  | (m_eto  & !clr_err);
            m_ecfg = m_set_cfg | (m_ecfg & !clr_err);
            m_prev = interupt_request;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("tx_ready", tx_ready, m_txq.size() < DEPTH);
        chk("tx_level", tx_level, m_txq.size());
        chk("rx_level", rx_level, m_rxq.size());
        chk("rx_valid", rx_valid, m_rxq.size() > 0);
        if (m_rxq.size() > 0) chk("rx_data", rx_data, m_rxq[0]);
        chk("busy", busy, m_age >= 0);
        chk("trans_en", trans_en, m_age == 0);
        chk("i_data_p", i_data_p, m_cur);
        chk("data_config", data_config, m_cfg);
        chk("err_timeout", err_timeout, m_eto);
        chk("err_cfg", err_cfg, m_ecfg);
    end

    // ---------------- emulated SPI core ----------------
    logic       core_mode = 1'b0;
    int         core_delay = 2;
    logic [7:0] core_xor = 8'hFF;
    int         cd = 0;

    initial forever begin
        @(negedge clk);
        if (core_mode) begin
            if (interupt_request) begin
                interupt_request = 1'b0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    interupt_request = 1'b1;
                    o_data_p = i_data_p ^ core_xor;
                end
            end else if (trans_en) begin
                cd = core_delay;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_silent();
        core_mode = 1'b0;
        cd = 0;
        interupt_request = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int g = 0;
        tx_data = b;
        tx_valid = 1'b1;
        while (!tx_ready && g < 200) begin tick(); g++; end
        chk("push_wait", tx_ready, 1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input logic [7:0] exp);
        chk("pop_valid", rx_valid, 1);
        chk("pop_data", rx_data, exp);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int g = 0;
        while ((busy || tx_level != 0) && g < budget) begin tick(); g++; end
        chk("wait_idle", busy || (tx_level != 0), 0);
    endtask

    initial begin
        int g, k, n;
        logic [7:0] e;
        repeat (3) tick();
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg", data_config, 0);
        rst = 1'b1;
        tick();

        // Single byte, reply 0x3C, launch latency.
        core_mode = 1'b1; core_delay = 10; core_xor = 8'h99;
        push(8'hA5);
        chk("t1_no_early_start", trans_en, 0);
        tick();
        chk("t1_trans_en_n2", trans_en, 1);
        chk("t1_i_data", i_data_p, 8'hA5);
        wait_idle(100);
        chk("t1_rx_data", rx_data, 8'h3C);
        chk("t1_rx_level", rx_level, 1);
        pop_rx(8'h3C);

        // Back-to-back bytes.
        core_delay = 2; core_xor = 8'hFF;
        push(8'h10); push(8'h20); push(8'h30);
        wait_idle(200);
        chk("t2_rx_level", rx_level, 3);
        pop_rx(8'hEF); pop_rx(8'hDF); pop_rx(8'hCF);

        // Reply on the last waiting cycle is captured; one later times out.
        core_delay = TO;
        push(8'h44);
        wait_idle(100);
        chk("t3_edge_last_cycle_err", err_timeout, 0);
        pop_rx(8'hBB);
        core_delay = TO + 1;
        push(8'h55);
        wait_idle(100);
        repeat (3) tick();
        chk("t3_late_err", err_timeout, 1);
        chk("t3_late_rx_level", rx_level, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t3_clr", err_timeout, 0);

        // Silent core: timeout latency, then a normal transfer.
        set_silent();
        push(8'h66);
        g = 0;
        while (!trans_en && g < 20) begin tick(); g++; end
        chk("t4_start_seen", trans_en, 1);
        k = 0;
        while (!err_timeout && k < 100) begin tick(); k++; end
        chk("t4_timeout_latency", k, TO + 1);
        chk("t4_rx_level", rx_level, 0);
        core_mode = 1'b1; core_delay = 3; core_xor = 8'hFF;
        clr_err = 1'b1;
        push(8'h77);
        clr_err = 1'b0;
        wait_idle(100);
        chk("t4_next_ok_err", err_timeout, 0);
        pop_rx(8'h88);

        // Config writes outside and inside IDLE.
        set_silent();
        push(8'h12);
        tick(); tick();
        cfg_in = 32'h0000_0083; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        chk("t5_cfg_blocked", data_config, 0);
        chk("t5_err_cfg", err_cfg, 1);
        clr_err = 1'b1; cfg_we = 1'b1; tick(); cfg_we = 1'b0; clr_err = 1'b0;
        chk("t5_set_wins", err_cfg, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t5_cleared", err_cfg, 0);
        wait_idle(100);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        chk("t5_cfg_idle", data_config, 32'h83);
        chk("t5_no_err", err_cfg, 0);
        core_mode = 1'b1; core_delay = 2;
        push(8'h13);
        cfg_in = 32'hDEAD_BEEF; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        chk("t5_start_cycle_tx", trans_en, 1);
        chk("t5_start_cycle_cfg", data_config, 32'hDEAD_BEEF);
        chk("t5_start_cycle_err", err_cfg, 0);
        wait_idle(100);
        pop_rx(8'hEC);

        // Fill both queues with the host never reading RX.
        set_silent();
        for (int i = 1; i <= 9; i++) push(i[7:0]);
        chk("t6_tx_full", tx_ready, 0);
        chk("t6_tx_level", tx_level, 8);
        tx_data = 8'h0A; tx_valid = 1'b1;
        interupt_request = 1'b1; o_data_p = i_data_p ^ core_xor;
        tick();
        interupt_request = 1'b0; core_mode = 1'b1; core_delay = 2;
        push(8'h0A);
        g = 0;
        while (!(rx_level == 8 && !busy) && g < 300) begin tick(); g++; end
        repeat (3) tick();
        chk("t6_stall_busy", busy, 0);
        chk("t6_rx_full", rx_level, 8);
        chk("t6_tx_left", tx_level, 2);
        rx_ready = 1'b1;
        k = 1; g = 0;
        while (k <= 10 && g < 400) begin
            if (rx_valid) begin
                e = k[7:0] ^ 8'hFF;
                chk("t6_drain", rx_data, e);
                k++;
            end
            tick(); g++;
        end
        rx_ready = 1'b0;
        chk("t6_drained", k, 11);
        wait_idle(100);

        // Core line held high across two transfers.
        set_silent();
        push(8'h21); push(8'h22);
        repeat (3) tick();
        interupt_request = 1'b1; o_data_p = 8'hB1;
        g = 0;
        while (!err_timeout && g < 100) begin tick(); g++; end
        chk("t7_rx_level", rx_level, 1);
        chk("t7_rx_data", rx_data, 8'hB1);
        chk("t7_tx_level", tx_level, 0);
        interupt_request = 1'b0;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        pop_rx(8'hB1);

        // Reset while waiting with three bytes queued.
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        repeat (3) tick();
        chk("t8_queued", tx_level, 3);
        chk("t8_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t8_tx_level", tx_level, 0);
        chk("t8_busy_rst", busy, 0);
        chk("t8_trans_en", trans_en, 0);
        chk("t8_i_data", i_data_p, 0);
        chk("t8_cfg", data_config, 0);
        chk("t8_tx_ready", tx_ready, 1);
        chk("t8_rx_valid", rx_valid, 0);
        tick(); tick();
        rst = 1'b1;
        n = 0;
        repeat (30) begin tick(); if (trans_en) n++; end
        chk("t8_no_start", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
